// File: rtl/instruction_fetch.sv
// Front-end fetch stage: boot-loads a program into instruction memory, then
// walks the PC and hands registered instruction/PC pairs to decode over valid/ready.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter logic [63:0] PC_STEP   = 64'd2,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_overflow,
    output logic [63:0] imem_address,
    output logic [31:0] imem_write_data,
    output logic        imem_write_en,
    output logic        imem_read_en,
    input  logic [31:0] imem_read_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // First byte address that no longer maps to a distinct memory word.
    localparam logic [63:0] LOAD_LIMIT = 64'(MEM_WORDS) * PC_STEP;

    state_t      state_reg;
    logic [63:0] load_ptr_reg;
    logic [63:0] pc_reg;
    logic [63:0] instr_pc_reg;
    logic [31:0] instr_reg;
    logic        instr_valid_reg;
    logic        load_overflow_reg;
    logic        fetch_slot;

    // A fetch slot opens whenever the output register is empty or being drained.
    assign fetch_slot = !instr_valid_reg || instr_ready;

    assign load_ready      = !reset && (state_reg == LOAD);
    assign imem_address    = (state_reg == LOAD) ? load_ptr_reg : pc_reg;
    assign imem_write_data = reset ? 32'd0 : load_data;
    assign imem_write_en   = !reset && (state_reg == LOAD) && load_valid;
    assign imem_read_en    = !reset && (state_reg == RUN) && fetch_slot;

    assign instr_valid   = instr_valid_reg;
    assign instr         = instr_reg;
    assign instr_pc      = instr_pc_reg;
    assign load_overflow = load_overflow_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= LOAD;
            load_ptr_reg      <= 64'd0;
            pc_reg            <= RESET_PC;
            instr_valid_reg   <= 1'b0;
            instr_reg         <= 32'd0;
            instr_pc_reg      <= 64'd0;
            load_overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_valid) begin
                        load_ptr_reg <= load_ptr_reg + PC_STEP;
                        // The write still goes out and aliases; only flag it.
                        if (load_ptr_reg >= LOAD_LIMIT) begin
                            load_overflow_reg <= 1'b1;
                        end
                        if (load_last) begin
                            state_reg <= RUN;
                            pc_reg    <= RESET_PC;
                        end
                    end
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc_reg          <= redirect_pc;
                        instr_valid_reg <= 1'b0;
                    end else if (fetch_slot) begin
                        instr_reg       <= imem_read_data;
                        instr_pc_reg    <= pc_reg;
                        instr_valid_reg <= 1'b1;
                        pc_reg          <= pc_reg + PC_STEP;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a cycle-level reference model feeds
// expected status and accepted-instruction queues that an independent monitor drains.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_overflow;
    logic [63:0] imem_address;
    logic [31:0] imem_write_data;
    logic        imem_write_en;
    logic        imem_read_en;
    logic [31:0] imem_read_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_last      (load_last),
        .load_ready     (load_ready),
        .load_overflow  (load_overflow),
        .imem_address   (imem_address),
        .imem_write_data(imem_write_data),
        .imem_write_en  (imem_write_en),
        .imem_read_en   (imem_read_en),
        .imem_read_data (imem_read_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Instruction memory driven purely by the DUT's write port.
    logic [31:0] mem [256];
    logic        mem_clear;
    assign imem_read_data = mem[imem_address[8:1]];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (imem_write_en) begin
            mem[imem_address[8:1]] <= imem_write_data;
        end
    end

    typedef struct {
        logic        known;
        logic        rst;
        logic        load_ready;
        logic        write_en;
        logic        read_en;
        logic        valid;
        logic        ovf;
        logic [63:0] addr;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic [31:0] wdata;
    } status_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } item_t;

    status_t status_q[$];
    item_t   accept_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit done  = 1'b0;

    // Reference model state: what the spec says the block holds right now.
    bit          m_known = 1'b0;
    bit          m_load;
    logic [63:0] m_ptr;
    logic [63:0] m_pc;
    bit          m_have;
    logic [31:0] m_instr;
    logic [63:0] m_ipc;
    bit          m_ovf;
    logic [31:0] ref_mem [256];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input bit rst, input bit lv, input bit last, input logic [31:0] ld,
                        input bit rv, input logic [63:0] rpc, input bit rdy);
        status_t s;
        @(negedge clk);
        reset          = rst;
        load_valid     = lv;
        load_last      = last;
        load_data      = ld;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;

        s.known      = m_known;
        s.rst        = rst;
        s.load_ready = !rst && m_known && m_load;
        s.write_en   = !rst && m_known && m_load && lv;
        s.read_en    = !rst && m_known && !m_load && (!m_have || rdy);
        s.valid      = m_have;
        s.ovf        = m_ovf;
        s.addr       = m_load ? m_ptr : m_pc;
        s.ipc        = m_ipc;
        s.ins        = m_instr;
        s.wdata      = ld;
        status_q.push_back(s);

        if (rst) begin
            m_known = 1'b1;
            m_load  = 1'b1;
            m_ptr   = 64'd0;
            m_pc    = 64'd0;
            m_have  = 1'b0;
            m_instr = 32'd0;
            m_ipc   = 64'd0;
            m_ovf   = 1'b0;
        end else if (m_load) begin
            if (lv) begin
                ref_mem[(m_ptr / 2) % 256] = ld;
                if (m_ptr >= 64'd512) m_ovf = 1'b1;
                m_ptr = m_ptr + 64'd2;
                if (last) begin
                    m_load = 1'b0;
                    m_pc   = 64'd0;
                end
            end
        end else begin
            if (m_have && rdy) accept_q.push_back('{ins: m_instr, pc: m_ipc});
            if (rv) begin
                m_pc   = rpc;
                m_have = 1'b0;
            end else if (!m_have || rdy) begin
                m_instr = ref_mem[(m_pc / 2) % 256];
                m_ipc   = m_pc;
                m_have  = 1'b1;
                m_pc    = m_pc + 64'd2;
            end
        end
    endtask

    task automatic idle_run(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 64'd0, rdy);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            bit          rdy;
            bit          rv;
            logic [63:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) rpc = {$urandom, $urandom};
            else rpc = 64'($urandom_range(0, 20) * 2);
            step(1'b0, 1'b0, 1'b0, $urandom, rv, rpc, rdy);
        end
    endtask

    task automatic load_words(input int n, input bit gaps);
        int k = 0;
        while (k < n) begin
            if (gaps && $urandom_range(0, 4) == 0) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b1, 64'd6, 1'b1);
            end else begin
                step(1'b0, 1'b1, (k == n - 1), $urandom, 1'($urandom_range(0, 1)), 64'd8, 1'b0);
                k++;
            end
        end
    endtask

    // Monitor: drains expected status every cycle and accepted items on handshakes.
    initial begin
        status_t s;
        item_t   it;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (status_q.size() == 0) begin
                chk("status_queue_empty", 64'd1, 64'd0);
            end else begin
                s = status_q.pop_front();
                chk("load_ready", 64'(load_ready), 64'(s.load_ready));
                chk("imem_write_en", 64'(imem_write_en), 64'(s.write_en));
                chk("imem_read_en", 64'(imem_read_en), 64'(s.read_en));
                if (!s.rst && s.known) chk("imem_address", imem_address, s.addr);
                if (s.write_en) chk("imem_write_data", 64'(imem_write_data), 64'(s.wdata));
                if (s.known) begin
                    chk("instr_valid", 64'(instr_valid), 64'(s.valid));
                    chk("load_overflow", 64'(load_overflow), 64'(s.ovf));
                    if (s.valid) begin
                        chk("instr", 64'(instr), 64'(s.ins));
                        chk("instr_pc", instr_pc, s.ipc);
                    end
                end
                if (!s.rst && s.known && !load_ready && instr_valid && instr_ready) begin
                    if (accept_q.size() == 0) begin
                        chk("accept_queue_empty", 64'd1, 64'd0);
                    end else begin
                        it = accept_q.pop_front();
                        chk("accepted_instr", 64'(instr), 64'(it.ins));
                        chk("accepted_pc", instr_pc, it.pc);
                        $display("accept instr=%h pc=%h", instr, instr_pc);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 64'd0; instr_ready = 1'b0;
        mem_clear = 1'b1;

        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b1);
        mem_clear = 1'b0;

        // Directed load of four words, then stream/stall/redirect.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 3), words[i], 1'b1, 64'd10, 1'b1);
        idle_run(1'b1);
        idle_run(1'b1);
        idle_run(1'b0);
        idle_run(1'b0);
        idle_run(1'b0);
        idle_run(1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 64'd4, 1'b1);
        idle_run(1'b1);
        idle_run(1'b1);
        idle_run(1'b1);
        random_run(60);

        // Overflow: 257 words with gaps; flag must persist into RUN.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
        load_words(257, 1'b1);
        random_run(40);

        // Reset in the middle of a stall.
        idle_run(1'b0);
        idle_run(1'b0);
        step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 64'd2, 1'b0);
        load_words(3, 1'b0);
        idle_run(1'b1);
        idle_run(1'b1);
        idle_run(1'b1);

        // PC wrap through the top of the address space.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        for (int i = 0; i < 5; i++) idle_run(1'b1);
        random_run(30);
        idle_run(1'b1);

        @(negedge clk);
        done = 1'b1;
        #5;
        if (status_q.size() != 0) chk("status_queue_left", 64'(status_q.size()), 64'd0);
        if (accept_q.size() != 0) chk("accept_queue_left", 64'(accept_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
